// File: rtl/pbtn_event_capture.sv
// pbtn_event_capture
// Converts debounced pushbutton and switch levels into sticky, clear-on-read
// events for a kcpsm6 input port:
//   - button press edges;
//   - optional press-and-hold auto-repeat;
//   - a switch-change flag;
//   - an overrun flag.
// It also raises a kcpsm6 interrupt/interrupt_ack handshake, so firmware does
// not need to poll the buttons.
//
// Status byte: evt_data = {1'b0, overrun, swtch_chg, pbtn_evt[4:0]}.

module pbtn_event_capture #(
  parameter int SIMULATE     = 0,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = (SIMULATE != 0) ? 5 : 50_000_000,
  parameter int REPEAT_RATE  = (SIMULATE != 0) ? 3 : 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] pbtn_db,
  input  logic [7:0] swtch_db,
  input  logic       rd_strobe,
  input  logic       interrupt_ack,
  output logic [7:0] evt_data,
  output logic       interrupt
);

  // The counter fires on the cycle in which it holds REPEAT_DELAY-1, so the
  // repeat event lands in the register exactly REPEAT_DELAY edges after the
  // last input change. Reloading to REPEAT_DELAY-REPEAT_RATE then yields one
  // repeat every REPEAT_RATE edges while the buttons stay held.
  localparam logic [26:0] RPT_FIRE   = 27'(REPEAT_DELAY - 1);
  localparam logic [26:0] RPT_RELOAD = 27'(REPEAT_DELAY - REPEAT_RATE);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_CLR
  } state_t;

  state_t      state;
  logic [4:0]  pb_q;
  logic [7:0]  sw_q;
  logic [26:0] hold_cnt;
  logic [4:0]  pbtn_evt;
  logic        swtch_chg;
  logic        overrun;

  logic [4:0]  press;
  logic [4:0]  rpt;
  logic [4:0]  new_pb;
  logic        sw_change;
  logic        hold_active;
  logic        rpt_fire;
  logic        pending;

  assign press       = pbtn_db & ~pb_q;
  assign sw_change   = |(swtch_db ^ sw_q);
  assign hold_active = (pbtn_db == pb_q) && (pbtn_db != 5'd0);
  assign rpt_fire    = (REPEAT_EN != 0) && hold_active && (hold_cnt == RPT_FIRE);
  assign rpt         = rpt_fire ? pbtn_db : 5'd0;
  assign new_pb      = press | rpt;
  assign pending     = |{overrun, swtch_chg, pbtn_evt};

  assign evt_data = {1'b0, overrun, swtch_chg, pbtn_evt};

  // Previous-cycle input copies for edge detection. This block has no reset
  // branch: a reset loads the same value, the current inputs, so levels that
  // are already active at reset never look like new edges afterwards.
  always_ff @(posedge clk) begin
    pb_q <= pbtn_db;
    sw_q <= swtch_db;
  end

  // Shared hold counter.
  // It restarts on any button change or when no button is held, and reloads
  // after each repeat so that later repeats come at the faster rate.
  always_ff @(posedge clk) begin
    if (reset || !hold_active || (REPEAT_EN == 0)) begin
      hold_cnt <= 27'd0;
    end else if (hold_cnt == RPT_FIRE) begin
      hold_cnt <= RPT_RELOAD;
    end else begin
      hold_cnt <= hold_cnt + 27'd1;
    end
  end

  // Sticky event bits: a read clears them, but a new event in the same cycle
  // wins. Overrun flags a button event that lands on a bit that is still
  // unread.
  always_ff @(posedge clk) begin
    if (reset) begin
      pbtn_evt  <= 5'd0;
      swtch_chg <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pbtn_evt  <= (rd_strobe ? 5'd0 : pbtn_evt) | new_pb;
      swtch_chg <= (rd_strobe ? 1'b0 : swtch_chg) | sw_change;
      overrun   <= (rd_strobe ? 1'b0 : overrun) |
                   ((|(new_pb & pbtn_evt)) & ~rd_strobe);
    end
  end

  // Interrupt handshake.
  // The request is held until it is acknowledged. The FSM then waits for the
  // firmware read before it can raise the request again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      interrupt <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending) begin
            state     <= REQ;
            interrupt <= 1'b1;
          end
        end
        REQ: begin
          if (interrupt_ack) begin
            state     <= WAIT_CLR;
            interrupt <= 1'b0;
          end
        end
        WAIT_CLR: begin
          if (rd_strobe) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule
